// File: rtl/riscv_ctrl_fsm.sv
// Multi-cycle RV32 control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with wait-timeout faults.
// Define RISCV_ILLEGAL_TRAP_EN to trap on instructions with no decoder class; otherwise they retire as NOPs.
module riscv_ctrl_fsm #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  input  logic        imem_rvalid_i,
  input  logic [6:0]  op_i,
  input  logic        r_type_i,
  input  logic        i_type_i,
  input  logic        s_type_i,
  input  logic        b_type_i,
  input  logic        u_type_i,
  input  logic        j_type_i,
  input  logic        branch_taken_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  input  logic        dmem_rvalid_i,
  output logic        ir_we_o,
  output logic        rf_we_o,
  output logic        pc_we_o,
  output logic [1:0]  pc_sel_o,
  output logic        retire_o,
  output logic [31:0] instret_o,
  output logic        fault_o,
  output logic [1:0]  fault_code_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_IMEM    = 2'd1,
    FC_DMEM    = 2'd2,
    FC_ILLEGAL = 2'd3
  } fault_e;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_REL = 2'd1,
    PC_RS1 = 2'd2
  } pc_sel_e;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  // The counter holds the number of already-elapsed empty wait cycles, so the
  // last permitted wait cycle is the one that sees TIMEOUT_CYCLES-1.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  wait_cnt_q;
  logic [31:0] instret_q;
  logic        fault_q;
  fault_e      fault_code_q;

  logic    no_class;
  logic    is_mem_op;
  logic    wait_expired;
  logic    imem_req;
  logic    dmem_req;
  logic    dmem_we;
  logic    ir_we;
  logic    rf_we;
  logic    pc_we;
  logic    retire;
  pc_sel_e pc_sel;

  assign no_class     = ~(r_type_i | i_type_i | s_type_i | b_type_i | u_type_i | j_type_i);
  assign is_mem_op    = (op_i == OP_LOAD) | s_type_i;
  assign wait_expired = (wait_cnt_q == TIMEOUT_LAST);

  // Controls are decoded from the current state plus live inputs because
  // ir_we, retire and the store/branch completions react in the same cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    retire   = 1'b0;
    pc_sel   = PC_SEQ;
    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_rvalid_i;
      end
      S_DECODE: begin
`ifndef RISCV_ILLEGAL_TRAP_EN
        if (no_class) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
`endif
      end
      S_EXECUTE: begin
        if (!is_mem_op && b_type_i) begin
          pc_we  = 1'b1;
          retire = 1'b1;
          pc_sel = branch_taken_i ? PC_REL : PC_SEQ;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = s_type_i;
        if (dmem_rvalid_i && s_type_i) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        retire = 1'b1;
        if (j_type_i) begin
          pc_sel = PC_REL;
        end else if (op_i == OP_JALR) begin
          pc_sel = PC_RS1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (reset) begin
      state_q      <= S_FETCH;
      wait_cnt_q   <= 8'd0;
      instret_q    <= 32'd0;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
    end else begin
      if (retire) begin
        instret_q <= instret_q + 32'd1;
      end
      // The wait counter is cleared whenever a wait completes, so it is
      // always zero on entry to FETCH or MEM.
      unique case (state_q)
        S_FETCH: begin
          if (imem_rvalid_i) begin
            state_q    <= S_DECODE;
            wait_cnt_q <= 8'd0;
          end else if (wait_expired) begin
            state_q      <= S_TRAP;
            fault_q      <= 1'b1;
            fault_code_q <= FC_IMEM;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        S_DECODE: begin
`ifdef RISCV_ILLEGAL_TRAP_EN
          if (no_class) begin
            state_q      <= S_TRAP;
            fault_q      <= 1'b1;
            fault_code_q <= FC_ILLEGAL;
          end else begin
            state_q <= S_EXECUTE;
          end
`else
          state_q <= no_class ? S_FETCH : S_EXECUTE;
`endif
        end
        S_EXECUTE: begin
          if (is_mem_op) begin
            state_q <= S_MEM;
          end else if (b_type_i) begin
            state_q <= S_FETCH;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_rvalid_i) begin
            state_q    <= s_type_i ? S_FETCH : S_WB;
            wait_cnt_q <= 8'd0;
          end else if (wait_expired) begin
            state_q      <= S_TRAP;
            fault_q      <= 1'b1;
            fault_code_q <= FC_DMEM;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        S_WB: begin
          state_q <= S_FETCH;
        end
        S_TRAP: begin
          state_q <= S_TRAP;
        end
        default: begin
          state_q    <= S_FETCH;
          wait_cnt_q <= 8'd0;
        end
      endcase
    end
  end

  // Reset silences every output in the same cycle, including the registered ones.
  assign imem_req_o   = ~reset & imem_req;
  assign dmem_req_o   = ~reset & dmem_req;
  assign dmem_we_o    = ~reset & dmem_we;
  assign ir_we_o      = ~reset & ir_we;
  assign rf_we_o      = ~reset & rf_we;
  assign pc_we_o      = ~reset & pc_we;
  assign retire_o     = ~reset & retire;
  assign pc_sel_o     = reset ? 2'b00 : pc_sel;
  assign instret_o    = reset ? 32'd0 : instret_q;
  assign fault_o      = ~reset & fault_q;
  assign fault_code_o = reset ? 2'b00 : fault_code_q;
  assign state_o      = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_riscv_ctrl_fsm.sv
// Scoreboard bench for riscv_ctrl_fsm: random instruction mix against a per-instruction cost model,
// plus directed reset, timeout, trap and illegal-opcode sequences.
module tb_riscv_ctrl_fsm;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_rvalid_i = 1'b0;
  logic [6:0]  op_i = 7'd0;
  logic        r_type_i = 1'b0, i_type_i = 1'b0, s_type_i = 1'b0;
  logic        b_type_i = 1'b0, u_type_i = 1'b0, j_type_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic        dmem_rvalid_i = 1'b0;
  logic        imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, rf_we_o, pc_we_o, retire_o, fault_o;
  logic [1:0]  pc_sel_o, fault_code_o;
  logic [31:0] instret_o;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  riscv_ctrl_fsm #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .imem_req_o(imem_req_o), .imem_rvalid_i(imem_rvalid_i), .op_i(op_i),
    .r_type_i(r_type_i), .i_type_i(i_type_i), .s_type_i(s_type_i),
    .b_type_i(b_type_i), .u_type_i(u_type_i), .j_type_i(j_type_i),
    .branch_taken_i(branch_taken_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_rvalid_i(dmem_rvalid_i),
    .ir_we_o(ir_we_o), .rf_we_o(rf_we_o), .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o),
    .retire_o(retire_o), .instret_o(instret_o),
    .fault_o(fault_o), .fault_code_o(fault_code_o), .state_o(state_o)
  );

  typedef enum logic [3:0] {C_R, C_I, C_U, C_J, C_JALR, C_LOAD, C_STORE, C_BRANCH, C_NOP} cls_e;

  // What one instruction must look like from fetch start to its retire cycle.
  typedef struct {
    int          cost;
    int          mem_cyc;
    int          we_cyc;
    int          rf_cnt;
    logic [1:0]  pc_sel;
    logic [31:0] instret;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [2:0]  trace[$];
  logic [31:0] model_instret = 32'd0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input logic [31:0] act, input logic [31:0] req, input string name);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Cost = fetch (waits + 1) + decode, then the class-specific tail.
  function automatic exp_t model(input cls_e c, input int wi, input int wd, input bit taken);
    exp_t e;
    e.cost    = wi + 2;
    e.mem_cyc = 0;
    e.we_cyc  = 0;
    e.rf_cnt  = 0;
    e.pc_sel  = 2'd0;
    e.instret = model_instret;
    case (c)
      C_NOP:    ;
      C_BRANCH: begin e.cost += 1; e.pc_sel = taken ? 2'd1 : 2'd0; end
      C_STORE:  begin e.cost += 2 + wd; e.mem_cyc = wd + 1; e.we_cyc = wd + 1; end
      C_LOAD:   begin e.cost += 3 + wd; e.mem_cyc = wd + 1; e.rf_cnt = 1; end
      C_J:      begin e.cost += 2; e.rf_cnt = 1; e.pc_sel = 2'd1; end
      C_JALR:   begin e.cost += 2; e.rf_cnt = 1; e.pc_sel = 2'd2; end
      default:  begin e.cost += 2; e.rf_cnt = 1; end
    endcase
    return e;
  endfunction

  task automatic set_flags(input cls_e c, input bit taken);
    {r_type_i, i_type_i, s_type_i, b_type_i, u_type_i, j_type_i} = 6'b0;
    branch_taken_i = taken;
    op_i = 7'b0000000;
    case (c)
      C_R:      begin r_type_i = 1'b1; op_i = 7'b0110011; end
      C_I:      begin i_type_i = 1'b1; op_i = 7'b0010011; end
      C_U:      begin u_type_i = 1'b1; op_i = 7'b0110111; end
      C_J:      begin j_type_i = 1'b1; op_i = 7'b1101111; end
      C_JALR:   begin i_type_i = 1'b1; op_i = 7'b1100111; end
      C_LOAD:   begin i_type_i = 1'b1; op_i = 7'b0000011; end
      C_STORE:  begin s_type_i = 1'b1; op_i = 7'b0100011; end
      C_BRANCH: begin b_type_i = 1'b1; op_i = 7'b1100011; end
      default:  ;
    endcase
  endtask

  // Called just after a rising edge; returns just after the edge that ends the retire cycle.
  task automatic run_instr(input cls_e c, input int wi, input int wd, input bit taken);
    int  fc = 0;
    int  dc = 0;
    int  n = 0;
    bit  done = 1'b0;
    set_flags(c, taken);
    exp_q.push_back(model(c, wi, wd, taken));
    model_instret++;
    trace.delete();
    while (!done && n < 300) begin
      trace.push_back(state_o);
      imem_rvalid_i = imem_req_o && (fc == wi);
      if (imem_req_o && fc != wi) fc++;
      dmem_rvalid_i = dmem_req_o && (dc == wd);
      if (dmem_req_o && dc != wd) dc++;
      #1;
      done = retire_o;
      @(posedge clk);
      #1;
      n++;
    end
    imem_rvalid_i = 1'b0;
    dmem_rvalid_i = 1'b0;
    if (!done) check(32'(done), 1, "retire_timeout");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_flags(C_STORE, 1'b1);
    imem_rvalid_i = 1'b1;
    dmem_rvalid_i = 1'b1;
    @(posedge clk);
    #1;
    check(32'({imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, rf_we_o, pc_we_o, retire_o,
               fault_o, fault_code_o, pc_sel_o, state_o}), 0, "outputs_in_reset");
    check(instret_o, 0, "instret_in_reset");
    imem_rvalid_i = 1'b0;
    dmem_rvalid_i = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    model_instret = 32'd0;
    #1;
  endtask

  // Monitor: accumulate per-instruction activity and settle it against the scoreboard at retire.
  int cyc = 0, last_cyc = 0, mem_cyc = 0, we_cyc = 0, rf_cnt = 0, ir_cnt = 0, pc_cnt = 0;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      last_cyc = cyc;
      {mem_cyc, we_cyc, rf_cnt, ir_cnt, pc_cnt} = '0;
    end else begin
      if (dmem_req_o) mem_cyc++;
      if (dmem_we_o)  we_cyc++;
      if (rf_we_o)    rf_cnt++;
      if (ir_we_o)    ir_cnt++;
      if (pc_we_o)    pc_cnt++;
      if (retire_o) begin
        if (exp_q.size() == 0) begin
          check(32'(retire_o), 0, "unexpected_retire");
        end else begin
          mon_e = exp_q.pop_front();
          check(cyc - last_cyc, mon_e.cost, "instr_cycles");
          check(32'(pc_sel_o), 32'(mon_e.pc_sel), "pc_sel");
          check(instret_o, mon_e.instret, "instret_before_retire");
          check(mem_cyc, mon_e.mem_cyc, "dmem_req_cycles");
          check(we_cyc, mon_e.we_cyc, "dmem_we_cycles");
          check(rf_cnt, mon_e.rf_cnt, "rf_we_cycles");
          check(ir_cnt, 1, "ir_we_cycles");
          check(pc_cnt, 1, "pc_we_cycles");
        end
        last_cyc = cyc;
        {mem_cyc, we_cyc, rf_cnt, ir_cnt, pc_cnt} = '0;
      end else if (pc_sel_o != 2'd0) begin
        check(32'(pc_sel_o), 0, "pc_sel_idle");
      end
    end
  end

  initial begin
    int   n;
    int   wi, wd;
    bit   tk;
    cls_e c;
    int   exp_tr[4];

    do_reset();
    check(32'(state_o), 0, "reset_state");
    check(instret_o, 0, "reset_instret");
    check(32'({fault_o, fault_code_o}), 0, "reset_fault");
    check(32'(imem_req_o), 1, "reset_imem_req");

    // ADD with zero-wait fetch: FETCH, DECODE, EXECUTE, WB.
    run_instr(C_R, 0, 0, 1'b0);
    exp_tr = '{0, 1, 2, 4};
    check(trace.size(), 4, "add_trace_len");
    for (int i = 0; i < 4; i++) check(32'(trace[i]), exp_tr[i], $sformatf("add_state_%0d", i));
    check(32'(state_o), 0, "add_back_to_fetch");
    check(instret_o, 1, "add_instret");

    run_instr(C_LOAD, 0, 2, 1'b0);
    run_instr(C_BRANCH, 0, 0, 1'b1);
    run_instr(C_BRANCH, 0, 0, 1'b0);
`ifndef RISCV_ILLEGAL_TRAP_EN
    run_instr(C_NOP, 0, 0, 1'b0);
`endif

    for (int k = 0; k < 150; k++) begin
`ifdef RISCV_ILLEGAL_TRAP_EN
      c = cls_e'(4'($urandom_range(0, 7)));
`else
      c = cls_e'(4'($urandom_range(0, 8)));
`endif
      wi = $urandom_range(0, 6);
      wd = $urandom_range(0, 6);
      tk = 1'($urandom_range(0, 1));
      run_instr(c, wi, wd, tk);
    end

    // Valid arriving in the last allowed wait cycle wins over the timeout.
    run_instr(C_R, TIMEOUT - 1, 0, 1'b0);
    check(32'(fault_o), 0, "late_imem_no_fault");
    run_instr(C_LOAD, 0, TIMEOUT - 1, 1'b0);
    run_instr(C_STORE, 3, TIMEOUT - 1, 1'b0);
    check(32'(fault_o), 0, "late_dmem_no_fault");

    // Reset in the middle of a load's MEM wait.
    set_flags(C_LOAD, 1'b0);
    imem_rvalid_i = 1'b1;
    n = 0;
    while (state_o != 3'd3 && n < 20) begin
      @(posedge clk);
      #1;
      imem_rvalid_i = 1'b0;
      n++;
    end
    check(32'(state_o), 3, "reach_mem");
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check(32'({dmem_req_o, retire_o, state_o}), 0, "mid_mem_reset_outputs");
    check(instret_o, 0, "mid_mem_reset_instret");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_instret = 32'd0;
    #1;
    check(32'(state_o), 0, "after_reset_state");
    check(instret_o, 0, "after_reset_instret");
    check(32'({retire_o, dmem_req_o}), 0, "after_reset_no_retire");

`ifdef RISCV_ILLEGAL_TRAP_EN
    do_reset();
    set_flags(C_NOP, 1'b0);
    imem_rvalid_i = 1'b1;
    @(posedge clk);
    #1;
    imem_rvalid_i = 1'b0;
    check(32'(state_o), 1, "illegal_decode");
    check(32'({retire_o, pc_we_o}), 0, "illegal_no_retire");
    @(posedge clk);
    #1;
    check(32'(state_o), 5, "illegal_trap_state");
    check(32'({fault_o, fault_code_o}), 32'b111, "illegal_fault");
`endif

    // Instruction fetch never answers.
    do_reset();
    set_flags(C_R, 1'b0);
    n = 0;
    while (state_o == 3'd0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(n, TIMEOUT, "fetch_timeout_cycles");
    check(32'(state_o), 5, "fetch_timeout_state");
    check(32'({fault_o, fault_code_o}), 32'b101, "fetch_timeout_fault");
    imem_rvalid_i = 1'b1;
    dmem_rvalid_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check(32'(state_o), 5, "trap_absorbing");
    check(32'({imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, rf_we_o, pc_we_o, retire_o}), 0,
          "trap_outputs_quiet");
    check(32'({fault_o, fault_code_o}), 32'b101, "trap_fault_sticky");

    // Data memory never answers a load.
    do_reset();
    set_flags(C_LOAD, 1'b0);
    imem_rvalid_i = 1'b1;
    n = 0;
    while (state_o != 3'd3 && n < 20) begin
      @(posedge clk);
      #1;
      imem_rvalid_i = 1'b0;
      n++;
    end
    n = 0;
    while (state_o == 3'd3 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(n, TIMEOUT, "mem_timeout_cycles");
    check(32'(state_o), 5, "mem_timeout_state");
    check(32'({fault_o, fault_code_o}), 32'b110, "mem_timeout_fault");
    check(32'(dmem_req_o), 0, "mem_timeout_req_low");

    check(exp_q.size(), 0, "scoreboard_drained");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
